// File: rtl/commit_trace_pkg.sv
// Shared constants for the commit trace checker: event kinds, error codes,
// event packing and the checker state encoding.
package commit_trace_pkg;

    localparam int EVT_W = 34;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_STORE = 2'd1;
    localparam logic [1:0] KIND_HALT  = 2'd2;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MISMATCH  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_MULTI     = 3'd3;
    localparam logic [2:0] ERR_EXTRA     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd5;
    localparam logic [2:0] ERR_BADKIND   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Events travel as {kind, addr, data}.
    function automatic logic [EVT_W-1:0] pack_evt(input logic [1:0] kind,
                                                  input logic [15:0] addr,
                                                  input logic [15:0] data);
        return {kind, addr, data};
    endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// trace_fifo: synchronous DEPTH x W FIFO holding expected commit events.
// Read data is the current head; the caller never pops empty or pushes full.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares the retire stream against queued expected events.
// Optional idle timeout is built only when COMMIT_TRACE_CHECKER_TIMEOUT_EN is defined.
module commit_trace_checker
    import commit_trace_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [1:0]       exp_kind,
    input  logic [15:0]      exp_addr,
    input  logic [15:0]      exp_data,
    input  logic             obs_reg_wr,
    input  logic [2:0]       obs_reg_addr,
    input  logic [15:0]      obs_reg_data,
    input  logic             obs_mem_wr,
    input  logic [15:0]      obs_mem_addr,
    input  logic [15:0]      obs_mem_data,
    input  logic             obs_halt,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [EVT_W-1:0] err_exp,
    output logic [EVT_W-1:0] err_obs,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] cycle_count,
    output state_t           dbg_state
);
    // Handshake: an expected event is taken on a clock edge where exp_valid and
    // exp_ready are both high; exp_ready depends only on registered state.

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        match_q, match_d, cycle_q, cycle_d;
    logic [2:0]              err_code_q, err_code_d;
    logic [EVT_W-1:0]        err_exp_q, err_exp_d, err_obs_q, err_obs_d;

    logic                    push, pop, fifo_empty, fifo_full;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [EVT_W-1:0]        head, head_z, obs_evt;
    logic [1:0]              head_kind;
    logic                    any_ev, multi_ev, fields_eq, raise;
    logic [2:0]              raise_code;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign exp_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !fifo_full;
    assign push      = exp_valid && exp_ready;

    trace_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (pack_evt(exp_kind, exp_addr, exp_data)),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_kind = head[33:32];
    assign head_z    = fifo_empty ? '0 : head;
    assign any_ev    = obs_reg_wr | obs_mem_wr | obs_halt;
    assign multi_ev  = (obs_reg_wr & obs_mem_wr) | (obs_reg_wr & obs_halt) | (obs_mem_wr & obs_halt);

    always_comb begin
        obs_evt = '0;
        if (obs_reg_wr) begin
            obs_evt = pack_evt(KIND_REG, {13'd0, obs_reg_addr}, obs_reg_data);
        end else if (obs_mem_wr) begin
            obs_evt = pack_evt(KIND_STORE, obs_mem_addr, obs_mem_data);
        end else if (obs_halt) begin
            obs_evt = pack_evt(KIND_HALT, 16'd0, 16'd0);
        end
    end

    // REG entries only carry a 3-bit register number; HALT carries nothing.
    always_comb begin
        fields_eq = 1'b0;
        case (head_kind)
            KIND_REG:   fields_eq = (obs_evt[33:32] == KIND_REG) &&
                                    (obs_evt[18:16] == head[18:16]) &&
                                    (obs_evt[15:0] == head[15:0]);
            KIND_STORE: fields_eq = (obs_evt == head);
            KIND_HALT:  fields_eq = (obs_evt[33:32] == KIND_HALT);
            default:    fields_eq = 1'b0;
        endcase
    end

`ifdef COMMIT_TRACE_CHECKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
`endif

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        cycle_d    = cycle_q;
        err_code_d = err_code_q;
        err_exp_d  = err_exp_q;
        err_obs_d  = err_obs_q;
        pop        = 1'b0;
        raise      = 1'b0;
        raise_code = ERR_NONE;
`ifdef COMMIT_TRACE_CHECKER_TIMEOUT_EN
        idle_d     = idle_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                cycle_d = sat_inc(cycle_q);
`ifdef COMMIT_TRACE_CHECKER_TIMEOUT_EN
                idle_d = any_ev ? '0 : idle_q + IDLE_W'(1);
                if (!any_ev && (idle_q + IDLE_W'(1) == IDLE_W'(TIMEOUT_CYC))) begin
                    raise      = 1'b1;
                    raise_code = ERR_TIMEOUT;
                end
`endif
                if (multi_ev) begin
                    raise      = 1'b1;
                    raise_code = ERR_MULTI;
                end else if (any_ev) begin
                    if (fifo_empty) begin
                        raise      = 1'b1;
                        raise_code = ERR_UNDERFLOW;
                    end else if (head_kind == 2'd3) begin
                        raise      = 1'b1;
                        raise_code = ERR_BADKIND;
                    end else if (!fields_eq) begin
                        raise      = 1'b1;
                        raise_code = ERR_MISMATCH;
                    end else begin
                        pop     = 1'b1;
                        match_d = sat_inc(match_q);
                        // A same-cycle push still counts as a trailing entry.
                        if (head_kind == KIND_HALT) begin
                            if (fifo_count == 1 && !push) begin
                                state_d = ST_DONE;
                            end else begin
                                raise      = 1'b1;
                                raise_code = ERR_EXTRA;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
        if (raise) begin
            state_d    = ST_ERR;
            err_code_d = raise_code;
            err_exp_d  = head_z;
            err_obs_d  = obs_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            match_q    <= '0;
            cycle_q    <= '0;
            err_code_q <= ERR_NONE;
            err_exp_q  <= '0;
            err_obs_q  <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            cycle_q    <= cycle_d;
            err_code_q <= err_code_d;
            err_exp_q  <= err_exp_d;
            err_obs_q  <= err_obs_d;
        end
    end

    assign pass        = (state_q == ST_DONE);
    assign fail        = (state_q == ST_ERR);
    assign err_code    = err_code_q;
    assign err_exp     = err_exp_q;
    assign err_obs     = err_obs_q;
    assign match_count = match_q;
    assign cycle_count = cycle_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_commit_trace_checker;
    import commit_trace_pkg::*;

    localparam int CNT_W = 32;

    logic             clk, rst_n, start;
    logic             exp_valid, exp_ready;
    logic [1:0]       exp_kind;
    logic [15:0]      exp_addr, exp_data;
    logic             obs_reg_wr, obs_mem_wr, obs_halt;
    logic [2:0]       obs_reg_addr;
    logic [15:0]      obs_reg_data, obs_mem_addr, obs_mem_data;
    logic             pass, fail;
    logic [2:0]       err_code;
    logic [EVT_W-1:0] err_exp, err_obs;
    logic [CNT_W-1:0] match_count, cycle_count;
    state_t           dbg_state;

    int errors = 0;
    int checks = 0;

    commit_trace_checker #(.DEPTH(8), .CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_kind(exp_kind), .exp_addr(exp_addr), .exp_data(exp_data),
        .obs_reg_wr(obs_reg_wr), .obs_reg_addr(obs_reg_addr), .obs_reg_data(obs_reg_data),
        .obs_mem_wr(obs_mem_wr), .obs_mem_addr(obs_mem_addr), .obs_mem_data(obs_mem_data),
        .obs_halt(obs_halt), .pass(pass), .fail(fail), .err_code(err_code),
        .err_exp(err_exp), .err_obs(err_obs),
        .match_count(match_count), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; exp_valid = 0; exp_kind = 0; exp_addr = 0; exp_data = 0;
        obs_reg_wr = 0; obs_reg_addr = 0; obs_reg_data = 0;
        obs_mem_wr = 0; obs_mem_addr = 0; obs_mem_data = 0; obs_halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        exp_valid = 1; exp_kind = k; exp_addr = a; exp_data = d;
        @(negedge clk);
        exp_valid = 0;
    endtask

    task automatic start_run();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic observe(input logic rw, input logic [2:0] ra, input logic [15:0] rd,
                           input logic mw, input logic [15:0] ma, input logic [15:0] md,
                           input logic h);
        obs_reg_wr = rw; obs_reg_addr = ra; obs_reg_data = rd;
        obs_mem_wr = mw; obs_mem_addr = ma; obs_mem_data = md; obs_halt = h;
        @(negedge clk);
        obs_reg_wr = 0; obs_mem_wr = 0; obs_halt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        // Reset state
        do_reset();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ready", exp_ready, 1);
        check("rst_passfail", {pass, fail}, 0);
        check("rst_code", err_code, 0);
        check("rst_counts", {match_count, cycle_count}, 0);

        // Clean run: REG, STORE, HALT
        push(KIND_REG, 16'h0003, 16'h1234);
        push(KIND_STORE, 16'h0040, 16'hBEEF);
        push(KIND_HALT, 16'h0000, 16'h0000);
        observe(1, 3'd3, 16'h1234, 0, 0, 0, 0);   // ignored in IDLE
        check("idle_ignores_obs", {fail, dbg_state}, {1'b0, ST_IDLE});
        start_run();
        check("run_state", dbg_state, ST_RUN);
        observe(1, 3'd3, 16'h1234, 0, 0, 0, 0);
        observe(0, 0, 0, 1, 16'h0040, 16'hBEEF, 0);
        check("pre_halt_pass", pass, 0);
        observe(0, 0, 0, 0, 0, 0, 1);
        check("clean_pass", pass, 1);
        check("clean_fail", fail, 0);
        check("clean_match", match_count, 3);
        check("clean_cycles", cycle_count, 3);
        check("done_ready", exp_ready, 0);
        repeat (3) @(negedge clk);
        check("done_frozen", {pass, cycle_count}, {1'b1, 32'd3});

        // REG data mismatch
        do_reset();
        push(KIND_REG, 16'h0001, 16'h0005);
        start_run();
        observe(1, 3'd1, 16'h0006, 0, 0, 0, 0);
        check("mm_fail", fail, 1);
        check("mm_code", err_code, ERR_MISMATCH);
        check("mm_exp", err_exp, {2'd0, 16'h0001, 16'h0005});
        check("mm_obs", err_obs, {2'd0, 16'h0001, 16'h0006});
        check("mm_match", match_count, 0);

        // Underflow on empty FIFO
        do_reset();
        start_run();
        observe(0, 0, 0, 1, 16'h0010, 16'h0000, 0);
        check("uf_code", {fail, err_code}, {1'b1, ERR_UNDERFLOW});

        // FIFO full: 8 pushes then a held-off 9th
        do_reset();
        for (int i = 0; i < 8; i++) push(KIND_REG, 16'(i), 16'(i + 16'h100));
        check("full_ready", exp_ready, 0);
        exp_valid = 1; exp_kind = KIND_HALT; exp_addr = 0; exp_data = 0;
        repeat (2) @(negedge clk);
        check("held_off", exp_ready, 0);
        start_run();
        observe(1, 3'd0, 16'h0100, 0, 0, 0, 0);
        check("pop_ready", exp_ready, 1);
        check("pop_match", match_count, 1);
        @(negedge clk);
        exp_valid = 0;
        check("refill_ready", exp_ready, 0);

        // REG number uses only addr[2:0]; STORE compares full address
        do_reset();
        push(KIND_REG, 16'hFFF9, 16'h00AA);
        push(KIND_STORE, 16'h0040, 16'hBEEF);
        start_run();
        observe(1, 3'd1, 16'h00AA, 0, 0, 0, 0);
        check("reg_hi_ignored", {fail, match_count}, {1'b0, 32'd1});
        observe(0, 0, 0, 1, 16'h0041, 16'hBEEF, 0);
        check("store_addr_mm", err_code, ERR_MISMATCH);
        check("store_addr_obs", err_obs, {2'd1, 16'h0041, 16'hBEEF});

        // Kind mismatch
        do_reset();
        push(KIND_STORE, 16'h0002, 16'h0007);
        start_run();
        observe(1, 3'd2, 16'h0007, 0, 0, 0, 0);
        check("kind_mm", err_code, ERR_MISMATCH);

        // Multiple simultaneous events
        do_reset();
        push(KIND_REG, 16'h0002, 16'h0007);
        start_run();
        observe(1, 3'd2, 16'h0007, 1, 16'h0002, 16'h0007, 0);
        check("multi_code", {fail, err_code}, {1'b1, ERR_MULTI});

        // HALT with a trailing entry
        do_reset();
        push(KIND_HALT, 0, 0);
        push(KIND_REG, 16'h0001, 16'h0001);
        start_run();
        observe(0, 0, 0, 0, 0, 0, 1);
        check("extra_code", {fail, err_code}, {1'b1, ERR_EXTRA});
        check("extra_match", match_count, 1);

        // Reserved kind at head
        do_reset();
        push(2'd3, 16'h0001, 16'h0001);
        start_run();
        observe(1, 3'd1, 16'h0001, 0, 0, 0, 0);
        check("badkind_code", err_code, ERR_BADKIND);

        // Idle RUN: timeout only when the feature is built
        do_reset();
        start_run();
        repeat (15) @(negedge clk);
        check("idle15_nofail", fail, 0);
        @(negedge clk);
`ifdef COMMIT_TRACE_CHECKER_TIMEOUT_EN
        check("timeout_code", {fail, err_code}, {1'b1, ERR_TIMEOUT});
        check("timeout_cycles", cycle_count, 16);
`else
        repeat (8) @(negedge clk);
        check("no_timeout", {fail, err_code}, {1'b0, ERR_NONE});
        check("idle_cycles", cycle_count, 24);
`endif

        // Asynchronous reset mid-run flushes everything
        do_reset();
        push(KIND_REG, 16'h0001, 16'h0011);
        push(KIND_REG, 16'h0002, 16'h0022);
        start_run();
        observe(1, 3'd1, 16'h0011, 0, 0, 0, 0);
        check("pre_rst_match", match_count, 1);
        #2 rst_n = 0;
        #1;
        check("async_state", dbg_state, ST_IDLE);
        check("async_outs", {pass, fail, err_code, match_count, cycle_count}, 0);
        check("async_ready", exp_ready, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start_run();
        observe(1, 3'd2, 16'h0022, 0, 0, 0, 0);
        check("flushed_uf", err_code, ERR_UNDERFLOW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
